// File: rtl/teatris_pkg.sv
// -----------------------------------------------------------------------------
// teatris_pkg
// Shared definitions for the map-memory arbiter: FSM state encoding and
// requester identifiers.
//   ARB_IDLE / ARB_SERVE0 / ARB_SERVE1 : arbiter FSM states (also exported on
//                                        db_estado, so the encoding is fixed)
//   REQ_DISP / REQ_GAME                : requester 0 (display scan) and
//                                        requester 1 (game datapath)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package teatris_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SERVE0 = 2'd1,
    ARB_SERVE1 = 2'd2
  } arb_state_e;

  localparam logic REQ_DISP = 1'b0;
  localparam logic REQ_GAME = 1'b1;

endpackage

// File: rtl/teatris_arb_wait_cnt.sv
// -----------------------------------------------------------------------------
// teatris_arb_wait_cnt
// Saturating wait counter for one requester. Counts cycles in which the
// requester asks (req) but is not granted (gnt); clears while the grant is
// held. starve goes high once the count reaches MAX and stays high until the
// grant arrives.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req, gnt   : request and current (registered) grant of this requester
//   starve     : counter has reached MAX
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module teatris_arb_wait_cnt #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic starve
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (gnt) begin
      cnt <= '0;
    end else if (req && (cnt != W'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starve = (cnt == W'(MAX));

endmodule

// File: rtl/teatris_mapa_arb.sv
// -----------------------------------------------------------------------------
// teatris_mapa_arb
// Arbiter/sequencer for the single-port board map memory. Requester 0 is the
// display scan (read only), requester 1 is the game datapath (read/write).
// Round-robin on simultaneous requests, a MAX_BURST access limit per grant,
// an atomic lock that extends a grant past the limit, and read-data routing
// that follows each read to its owner even after the grant has moved on.
//
// Build option: define TEATRIS_ARB_STARVE_EN to add per-requester wait
// counters; a requester that has waited STARVE_MAX cycles overrides the
// other side's lock. Without it a lock is honored indefinitely.
//
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   req0/1, lock0/1                : request, hold-grant-past-burst-limit
//   addr0/1, we0/1, wdata0/1       : access command (we0 ignored)
//   gnt0/1                         : grant (decoded from state register)
//   rvalid0/1, rdata               : read return, rdata shared
//   mem_en/we/addr/wdata, mem_rdata: memory macro port, 1-cycle read latency
//   busy                           : any grant active
//   db_estado                      : FSM state
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module teatris_mapa_arb
  import teatris_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 4,
  parameter int MAX_BURST  = 8,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        db_estado
);

  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e        state, state_nx;
  logic              last;      // requester served most recently
  logic [BW-1:0]     burst_cnt;
  logic              rd_vld;    // a read was issued last cycle
  logic              rd_who;    // owner of that read
  logic              acc0, acc1;
  logic              burst_done;
  logic              starve0, starve1;

  // Requester 0 never writes.
  logic unused_we0;
  assign unused_we0 = we0;

  assign acc0 = (state == ARB_SERVE0) && req0;
  assign acc1 = (state == ARB_SERVE1) && req1;

  // Counts the access happening this cycle, so the switch lands right after
  // the MAX_BURST-th access with no idle cycle in between.
  assign burst_done = (burst_cnt == BW'(MAX_BURST)) ||
                      ((acc0 || acc1) && (burst_cnt == BW'(MAX_BURST - 1)));

`ifdef TEATRIS_ARB_STARVE_EN
  teatris_arb_wait_cnt #(.MAX(STARVE_MAX)) u_wait0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req0),
    .gnt    (gnt0),
    .starve (starve0)
  );
  teatris_arb_wait_cnt #(.MAX(STARVE_MAX)) u_wait1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req1),
    .gnt    (gnt1),
    .starve (starve1)
  );
`else
  logic unused_starve;
  assign unused_starve = (STARVE_MAX > 0);
  assign starve0 = 1'b0;
  assign starve1 = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      ARB_IDLE: begin
        if (req0 && req1) state_nx = last ? ARB_SERVE0 : ARB_SERVE1;
        else if (req0)    state_nx = ARB_SERVE0;
        else if (req1)    state_nx = ARB_SERVE1;
      end
      ARB_SERVE0: begin
        if (!req0)        state_nx = req1 ? ARB_SERVE1 : ARB_IDLE;
        else if (req1 && ((burst_done && !lock0) || starve1))
                          state_nx = ARB_SERVE1;
      end
      ARB_SERVE1: begin
        if (!req1)        state_nx = req0 ? ARB_SERVE0 : ARB_IDLE;
        else if (req0 && ((burst_done && !lock1) || starve0))
                          state_nx = ARB_SERVE0;
      end
      default:            state_nx = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
      rd_vld    <= 1'b0;
      rd_who    <= REQ_DISP;
    end else begin
      state <= state_nx;
      if ((state != ARB_IDLE) && (state_nx != state))
        last <= (state == ARB_SERVE1);
      if (state_nx != state)
        burst_cnt <= '0;
      else if ((acc0 || acc1) && (burst_cnt != BW'(MAX_BURST)))
        burst_cnt <= burst_cnt + 1'b1;
      rd_vld <= mem_en && !mem_we;
      rd_who <= acc1 ? REQ_GAME : REQ_DISP;
    end
  end

  assign gnt0      = (state == ARB_SERVE0);
  assign gnt1      = (state == ARB_SERVE1);
  assign busy      = gnt0 | gnt1;
  assign db_estado = state;

  assign mem_en    = acc0 | acc1;
  assign mem_we    = acc1 && we1;
  assign mem_addr  = acc1 ? addr1  : (acc0 ? addr0  : '0);
  assign mem_wdata = acc1 ? wdata1 : (acc0 ? wdata0 : '0);

  assign rvalid0   = rd_vld && (rd_who == REQ_DISP);
  assign rvalid1   = rd_vld && (rd_who == REQ_GAME);
  assign rdata     = rd_vld ? mem_rdata : '0;

endmodule

// File: tb/tb_teatris_mapa_arb.sv
// -----------------------------------------------------------------------------
// tb_teatris_mapa_arb
// Self-checking bench for teatris_mapa_arb. A behavioral single-port memory
// with one-cycle read latency sits on the memory port. Each cycle the tick
// task compares grants/state/memory strobes against the grantee the scenario
// expects, pushes every expected read return to a queue, and pops it one
// cycle later against rvalid0/rvalid1/rdata.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_teatris_mapa_arb;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, req1, lock0, lock1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy;
  logic [1:0]        db_estado;

  typedef struct packed {
    logic              who;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] mem [64];
  int                n_cmp = 0;
  int                n_err = 0;
  int                cyc   = 0;
  string             cur_test;
  logic              smp_rvalid0;
  logic [DATA_W-1:0] smp_rdata;

  always #5 clk = ~clk;

  teatris_mapa_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .lock0     (lock0),
    .lock1     (lock1),
    .addr0     (addr0),
    .addr1     (addr1),
    .we0       (we0),
    .we1       (we1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .db_estado (db_estado)
  );

  // Memory macro model: synchronous write, registered read.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // One clock cycle. exp_g is the expected grantee this cycle (-1 = none).
  // Inputs are already set; outputs are sampled at the falling edge.
  task automatic tick(input int exp_g);
    exp_t              e;
    logic              ev0, ev1, acc, wr;
    logic [1:0]        exp_st;
    logic [ADDR_W-1:0] ea;
    @(negedge clk);
    ev0 = 1'b0; ev1 = 1'b0; e = '0;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      ev0 = !e.who;
      ev1 = e.who;
    end
    n_cmp++;
    if ({rvalid0, rvalid1} !== {ev0, ev1}) begin
      n_err++;
      $display("FAIL %s c%0d rvalid: got %b%b want %b%b", cur_test, cyc,
               rvalid0, rvalid1, ev0, ev1);
    end
    if (ev0 || ev1) begin
      n_cmp++;
      if (rdata !== e.data) begin
        n_err++;
        $display("FAIL %s c%0d rdata: got %h want %h", cur_test, cyc, rdata, e.data);
      end
    end
    exp_st = (exp_g < 0) ? 2'd0 : ((exp_g == 0) ? 2'd1 : 2'd2);
    n_cmp++;
    if ({gnt0, gnt1, busy, db_estado} !== {exp_g == 0, exp_g == 1, exp_g >= 0, exp_st}) begin
      n_err++;
      $display("FAIL %s c%0d grant: got gnt=%b%b busy=%b st=%0d want gnt=%b%b busy=%b st=%0d",
               cur_test, cyc, gnt0, gnt1, busy, db_estado,
               exp_g == 0, exp_g == 1, exp_g >= 0, exp_st);
    end
    acc = ((exp_g == 0) && req0) || ((exp_g == 1) && req1);
    wr  = (exp_g == 1) && req1 && we1;
    ea  = (exp_g == 1) ? addr1 : addr0;
    n_cmp++;
    if ({mem_en, mem_we} !== {acc, wr}) begin
      n_err++;
      $display("FAIL %s c%0d mem_en/we: got %b%b want %b%b", cur_test, cyc,
               mem_en, mem_we, acc, wr);
    end
    if (acc) begin
      n_cmp++;
      if (mem_addr !== ea) begin
        n_err++;
        $display("FAIL %s c%0d mem_addr: got %h want %h", cur_test, cyc, mem_addr, ea);
      end
    end
    if (wr) begin
      n_cmp++;
      if (mem_wdata !== wdata1) begin
        n_err++;
        $display("FAIL %s c%0d mem_wdata: got %h want %h", cur_test, cyc, mem_wdata, wdata1);
      end
    end
    if (acc && !wr) begin
      e.who  = (exp_g == 1);
      e.data = mem[ea];
      exp_q.push_back(e);
    end
    smp_rvalid0 = rvalid0;
    smp_rdata   = rdata;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cur_test = "reset";
    rst_n = 1'b0;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy} !== 7'b0) begin
      n_err++;
      $display("FAIL reset flags: got %b want 0",
               {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy});
    end
    n_cmp++;
    if ({rdata, mem_addr, mem_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset data: got rdata=%h addr=%h wdata=%h want 0",
               rdata, mem_addr, mem_wdata);
    end
    n_cmp++;
    if (db_estado !== 2'd0) begin
      n_err++;
      $display("FAIL reset state: got %0d want 0", db_estado);
    end
    @(posedge clk);
    #1;
    // Release with both requesting: req0 must win first.
    rst_n = 1'b1; req0 = 1; req1 = 1; addr0 = 6'h05; addr1 = 6'h06;
    tick(-1);
    tick(0);
    tick(0);
    req0 = 0;
    tick(0);          // dropped request: grant still up, no access
    tick(1);          // requester 1 follows with no grant gap
    req1 = 0;
    tick(1);
    tick(-1);
  endtask

  task automatic test_burst;
    cur_test = "burst";
    req1 = 1; lock1 = 0; we1 = 0; addr1 = '0;
    tick(-1);
    for (int c = 1; c <= 16; c++) begin
      req0  = (c >= 3) && (c <= 10);
      req1  = (c <= 15);
      addr1 = ADDR_W'(c);
      addr0 = ADDR_W'(32 + c);
      tick(((c <= 8) || (c >= 12)) ? 1 : 0);
    end
    req0 = 0; req1 = 0;
    tick(-1);
  endtask

  task automatic test_single_write;
    cur_test = "write";
    req1 = 1; we1 = 1; addr1 = 6'h2A; wdata1 = 4'h5;
    tick(-1);
    tick(1);
    req1 = 0; we1 = 0;
    tick(1);
    tick(-1);
    n_cmp++;
    if (mem[6'h2A] !== 4'h5) begin
      n_err++;
      $display("FAIL write mem[2A]: got %h want 5", mem[6'h2A]);
    end
  endtask

  task automatic test_lock;
    cur_test = "lock";
    req1 = 1; lock1 = 1; we1 = 0; addr1 = 6'h10; addr0 = 6'h11;
    tick(-1);
`ifdef TEATRIS_ARB_STARVE_EN
    // req0 waits cycles 2..18: its counter reaches 16 after cycle 17, the
    // lock is overridden in cycle 18 and gnt0 appears in cycle 19.
    for (int c = 1; c <= 22; c++) begin
      req1 = (c <= 21);
      req0 = (c >= 2) && (c <= 19);
      tick((c <= 18) ? 1 : ((c <= 20) ? 0 : 1));
    end
`else
    for (int c = 1; c <= 33; c++) begin
      req1 = (c <= 30);
      req0 = (c >= 2) && (c <= 32);
      tick((c <= 31) ? 1 : 0);
    end
`endif
    req0 = 0; req1 = 0; lock1 = 0;
    tick(-1);
  endtask

  task automatic test_read_latency;
    cur_test = "rd_latency";
    req0 = 1; addr0 = 6'h03;
    tick(-1);
    tick(0);
    req0 = 0;
    tick(0);
    n_cmp++;
    if ({smp_rvalid0, smp_rdata} !== {1'b1, 4'h9}) begin
      n_err++;
      $display("FAIL rd_latency: got rvalid0=%b rdata=%h want 1/9", smp_rvalid0, smp_rdata);
    end
    tick(-1);
  endtask

  task automatic test_reset_mid;
    cur_test = "reset_mid";
    req1 = 1; we1 = 0; addr1 = 6'h07;
    tick(-1);
    tick(1);          // read in flight
    rst_n = 1'b0;
    exp_q.delete();   // the pending return is discarded
    tick(-1);
    rst_n = 1'b1; req1 = 0;
    tick(-1);
    req0 = 1; req1 = 1; addr0 = 6'h08;
    tick(-1);
    tick(0);          // last restored to 1: requester 0 wins
    req0 = 0; req1 = 0;
    tick(0);
    tick(-1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = DATA_W'(i * 5 + 1);
    mem[3] = 4'h9;
    test_reset();
    test_burst();
    test_single_write();
    test_lock();
    test_read_latency();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
